// File: rtl/hack_alu_pkg.sv
// Shared definitions for blocks that sequence the external Hack ALU.
//
// Contents:
//   ALU_CTL_ADD  - control word that makes the ALU compute x + y
//   ALU_CTL_ZERO - control word that makes the ALU output constant zero
//   mul_state_t  - state encoding for the shift-and-add multiplier FSM
//
// Control words are packed in the order {zx, nx, zy, ny, f, no}.
package hack_alu_pkg;

  localparam logic [5:0] ALU_CTL_ADD  = 6'b000010;
  localparam logic [5:0] ALU_CTL_ZERO = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/hack_mul_seq.sv
// Multi-cycle 16x16 unsigned shift-and-add multiplier.
//
// Every addition is performed by the external Hack ALU: this block drives
// alu_x/alu_y and the six control bits and consumes alu_out in the same cycle.
// The result is the low 16 bits of a*b plus an overflow flag that is set when
// the true product does not fit in 16 bits.
//
// Ports:
//   clock, reset_n        - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     - operand handshake (in_ready high only in IDLE)
//   in_a, in_b            - multiplicand, multiplier
//   out_valid/out_ready   - result handshake (out_valid high only in DONE)
//   out_p, out_ovf        - low product bits, overflow flag
//   busy                  - high while iterating (ADD or DBL)
//   alu_x, alu_y, alu_zx..alu_no - ALU operands and control
//   alu_out               - combinational ALU result
//
// Optional build macro:
//   HACK_MUL_EARLY_EXIT_EN - finish as soon as no multiplier bits remain,
//                            instead of always running ITER iterations.
module hack_mul_seq
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_ovf,
  output logic             busy,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  mul_state_t       state, state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [4:0]       cnt;
  logic             ovf;

  logic [5:0]       alu_ctl;
  logic [WIDTH-1:0] mplier_shr;
  logic             add_carry;
  logic             dbl_lost;
  logic             last_iter;

  // The multiplier after this iteration's bit has been consumed; bit 0 of it
  // decides whether the next iteration needs an ADD.
  assign mplier_shr = mplier >> 1;

  // Unsigned carry out of acc + mcand, reconstructed from the MSBs because
  // the ALU does not expose its carry.
  assign add_carry = (acc[WIDTH-1] & mcand[WIDTH-1]) |
                     ((acc[WIDTH-1] | mcand[WIDTH-1]) & ~alu_out[WIDTH-1]);

  // Doubling drops mcand's MSB; that only matters if more multiplier bits
  // will still add the (now truncated) multiplicand.
  assign dbl_lost = mcand[WIDTH-1] & (mplier_shr != '0);

`ifdef HACK_MUL_EARLY_EXIT_EN
  assign last_iter = (cnt == 5'(ITER - 1)) || (mplier_shr == '0);
`else
  assign last_iter = (cnt == 5'(ITER - 1));
`endif

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctl;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ADD) || (state == ST_DBL);
  assign out_p     = acc;
  assign out_ovf   = ovf;

  // Next-state and ALU drive. Outside ADD/DBL the ALU is parked on constant
  // zero so the shared unit sees quiet operands when this block is idle.
  always_comb begin
    state_next = state;
    alu_ctl    = ALU_CTL_ZERO;
    alu_x      = '0;
    alu_y      = '0;
    case (state)
      ST_IDLE: begin
        if (in_valid) state_next = in_b[0] ? ST_ADD : ST_DBL;
      end
      ST_ADD: begin
        alu_ctl    = ALU_CTL_ADD;
        alu_x      = acc;
        alu_y      = mcand;
        state_next = ST_DBL;
      end
      ST_DBL: begin
        alu_ctl = ALU_CTL_ADD;
        alu_x   = mcand;
        alu_y   = mcand;
        if (last_iter)          state_next = ST_DONE;
        else if (mplier_shr[0]) state_next = ST_ADD;
        else                    state_next = ST_DBL;
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Datapath registers. acc and ovf stay untouched in DONE so the result is
  // held stable for as long as the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= in_a;
            mplier <= in_b;
            cnt    <= '0;
            ovf    <= 1'b0;
          end
        end
        ST_ADD: begin
          acc <= alu_out;
          ovf <= ovf | add_carry;
        end
        ST_DBL: begin
          mcand  <= alu_out;
          mplier <= mplier_shr;
          cnt    <= cnt + 5'd1;
          ovf    <= ovf | dbl_lost;
        end
        default: ;
      endcase
    end
  end

endmodule
